fault_campaign_ctrl: RTL and testbench
======================================

Name: fault_campaign_ctrl

Overview:
Sequential controller that runs a complete stuck-at fault campaign against the good/faulty full-adder pair and its comparators.
- Upstream side: drives the input vector {A,B,Cin}, fault_enable, stuck_val and a fault-site select into the faulty adder.
- Downstream side: consumes the two comparator flags (Sum, Cout) and reports per-fault detection plus a running detected count.
- Replaces the open-loop testbench loop with synthesizable hardware.

Parameters:
NUM_SITES, 4, number of injectable fault sites; site index 0..NUM_SITES-1
VEC_W, 3, input vector width; vectors 0..2^VEC_W-1 applied in ascending order
SETTLE_CYC, 1, wait cycles between applying a vector and sampling the flags; 0 allowed
SITE_W, $clog2(NUM_SITES) (min 1), site index width
CNT_W, $clog2(2*NUM_SITES+1), detected-count width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  begin campaign; sampled only in IDLE
abort  in  1  synchronous abort; return to IDLE, no done
vec  out  VEC_W  applied vector, MSB=A, then B, LSB=Cin
fault_enable  out  1  fault injection active
stuck_val  out  1  stuck-at value of the current fault
fault_site  out  SITE_W  current fault site
fault_sum  in  1  Sum comparator flag
fault_cout  in  1  Cout comparator flag
busy  out  1  campaign in progress
det_valid  out  1  one-cycle pulse; per-fault result fields valid
det_site  out  SITE_W  site of the reported fault
det_stuck  out  1  stuck value of the reported fault
det_hit  out  1  fault detected by at least one vector
det_first_vec  out  VEC_W  first detecting vector; 0 when det_hit=0
detected_count  out  CNT_W  running count of detected faults
done  out  1  one-cycle pulse at campaign end

Behaviour:
- Reset (async, immediate):
  - State IDLE.
  - All outputs 0, including vec, fault_site, stuck_val, fault_enable, busy, det_*, detected_count, done.
- States: IDLE, APPLY, WAIT, SAMPLE, REPORT, DONE.
- IDLE:
  - busy=0, fault_enable=0.
  - On start=1: load site=0, stuck=0, vec=0, hit=0; clear detected_count; go to APPLY.
- APPLY (1 cycle):
  - busy=1, fault_enable=1; vec/site/stuck_val held stable.
  - Go to WAIT if SETTLE_CYC>0, else SAMPLE.
- WAIT: stay SETTLE_CYC cycles (internal counter), then go to SAMPLE.
- SAMPLE (1 cycle):
  - d = fault_sum | fault_cout.
  - If d=1 and hit=0: set hit=1 and first_vec=vec.
  - If vec==2^VEC_W-1: go to REPORT.
  - Otherwise vec+1 and go to APPLY.
- Per-vector cost: SETTLE_CYC+2 cycles.
- REPORT (1 cycle):
  - det_valid=1; det_site, det_stuck, det_hit, det_first_vec reflect the finished fault.
  - detected_count increments the same cycle if hit (visible the next cycle).
  - Then clear hit and vec.
  - Fault order: stuck 0→1 within a site, then site+1.
  - After site NUM_SITES-1 with stuck=1, go to DONE; otherwise go to APPLY.
- DONE (1 cycle): done=1, fault_enable=0, busy=0; go to IDLE.
- det_* fields hold their last values until the next REPORT.
- detected_count holds until the next start.
- Cycle budget with defaults: 8 faults × (8×3+1) = 200 cycles from APPLY entry to DONE.
- start while busy: ignored.
- abort (any non-IDLE state): next cycle IDLE, fault_enable=0, busy=0, no det_valid, no done; detected_count holds its partial value.
  - abort has priority over every transition.
  - start and abort both high in IDLE: abort wins and the campaign does not start.
- Reset mid-campaign: immediate return to the reset state; no pulses emitted.
- Flags are ignored outside SAMPLE.
- Counters saturate-free by construction: vec wraps only via the REPORT clear.

Optional Feature:
Macro FAULT_DROP_EN.
- Defined: fault dropping. In SAMPLE, a first detection (d=1, hit=0) goes straight to REPORT, skipping the remaining vectors of that fault. det_first_vec and det_hit are unchanged in meaning.
- Undefined: every fault is exercised on all 2^VEC_W vectors regardless of detection.

Test Plan:
- Bench wiring for all scenarios: defaults; faulty adder fault node X1 (A^B) enabled only when fault_enable && fault_site==0; sites 1-3 never fault.
- Default campaign: reset, pulse start → 8 det_valid pulses in order:
  - (0,0): hit=1, first_vec=2
  - (0,1): hit=1, first_vec=0
  - sites 1-3, both stuck values: hit=0, first_vec=0
  - done exactly 200 cycles after the first APPLY; detected_count=2.
- SETTLE_CYC=0: same results; done 136 cycles (8×(8×2+1)) after the first APPLY.
- FAULT_DROP_EN defined: fault (0,0) REPORT after 3 vectors; fault (0,1) REPORT after 1 vector; undetected faults take the full 8 vectors; detected_count=2.
- Abort: assert abort during fault (0,1) WAIT → next cycle IDLE, fault_enable=0, no done, detected_count=1; a new start restarts from site 0 with count cleared.
- Async reset: assert rst mid-SAMPLE between clock edges → all outputs 0 immediately; start pressed during busy has no effect.

Source files
------------

// File: rtl/fault_campaign_ctrl.sv
// fault_campaign_ctrl
// Runs a complete stuck-at fault campaign against a good/faulty full-adder
// pair. For every fault (site, stuck value) it walks the input vectors in
// ascending order, samples the comparator flags after a settle time, and
// reports a per-fault result along with a running detected count.
//
// Optional build macro: FAULT_DROP_EN. When defined, a fault stops at its
// first detecting vector and goes straight to its report. When undefined,
// every fault is run over all vectors.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start, fault injection off
// APPLY  | current vector/site/stuck driven, fault injection on
// WAIT   | settle time before the flags are sampled
// SAMPLE | flags sampled, first detection captured, vector advanced
// REPORT | per-fault result presented, move on to the next fault
// DONE   | one-cycle end-of-campaign pulse
module fault_campaign_ctrl #(
    parameter int NUM_SITES  = 4,
    parameter int VEC_W      = 3,
    parameter int SETTLE_CYC = 1,
    parameter int SITE_W     = (NUM_SITES > 1) ? $clog2(NUM_SITES) : 1,
    parameter int CNT_W      = $clog2(2 * NUM_SITES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [VEC_W-1:0]  vec,
    output logic              fault_enable,
    output logic              stuck_val,
    output logic [SITE_W-1:0] fault_site,
    input  logic              fault_sum,
    input  logic              fault_cout,
    output logic              busy,
    output logic              det_valid,
    output logic [SITE_W-1:0] det_site,
    output logic              det_stuck,
    output logic              det_hit,
    output logic [VEC_W-1:0]  det_first_vec,
    output logic [CNT_W-1:0]  detected_count,
    output logic              done
);

`ifdef FAULT_DROP_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0]  SET_LOAD  = (SETTLE_CYC > 0) ? SET_W'(SETTLE_CYC - 1) : '0;
    localparam logic [VEC_W-1:0]  VEC_LAST  = '1;
    localparam logic [SITE_W-1:0] SITE_LAST = SITE_W'(NUM_SITES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_SAMPLE,
        S_REPORT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [VEC_W-1:0]  vec_q;
    logic [SITE_W-1:0] site_q;
    logic              stuck_q;
    logic              hit_q;
    logic [VEC_W-1:0]  first_q;
    logic [SET_W-1:0]  settle_q;
    logic [CNT_W-1:0]  count_q;
    logic [SITE_W-1:0] det_site_q;
    logic              det_stuck_q;
    logic              det_hit_q;
    logic [VEC_W-1:0]  det_fv_q;

    logic first_det;
    logic last_fault;
    logic last_vec;
    logic settle_end;

    assign first_det  = (fault_sum | fault_cout) & ~hit_q;
    assign last_fault = (site_q == SITE_LAST) && stuck_q;
    assign last_vec   = (vec_q == VEC_LAST);
    assign settle_end = (settle_q == '0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state strobes; abort overrides every transition
    always_comb begin
        state_nxt    = state;
        busy         = 1'b0;
        fault_enable = 1'b0;
        det_valid    = 1'b0;
        done         = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_APPLY;
            end
            S_APPLY: begin
                busy         = 1'b1;
                fault_enable = 1'b1;
                state_nxt    = (SETTLE_CYC > 0) ? S_WAIT : S_SAMPLE;
            end
            S_WAIT: begin
                busy         = 1'b1;
                fault_enable = 1'b1;
                if (settle_end) state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                busy         = 1'b1;
                fault_enable = 1'b1;
                if (last_vec || (DROP_EN && first_det)) state_nxt = S_REPORT;
                else                                    state_nxt = S_APPLY;
            end
            S_REPORT: begin
                busy         = 1'b1;
                fault_enable = 1'b1;
                det_valid    = 1'b1;
                state_nxt    = last_fault ? S_DONE : S_APPLY;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    // Vector/fault walk, detection capture, result registers and count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q       <= '0;
            site_q      <= '0;
            stuck_q     <= 1'b0;
            hit_q       <= 1'b0;
            first_q     <= '0;
            settle_q    <= '0;
            count_q     <= '0;
            det_site_q  <= '0;
            det_stuck_q <= 1'b0;
            det_hit_q   <= 1'b0;
            det_fv_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        vec_q   <= '0;
                        site_q  <= '0;
                        stuck_q <= 1'b0;
                        hit_q   <= 1'b0;
                        first_q <= '0;
                        count_q <= '0;
                    end
                end
                S_APPLY: begin
                    settle_q <= SET_LOAD;
                end
                S_WAIT: begin
                    if (!settle_end) settle_q <= settle_q - SET_W'(1);
                end
                S_SAMPLE: begin
                    if (first_det) begin
                        hit_q   <= 1'b1;
                        first_q <= vec_q;
                    end
                    // vec is left on the last applied vector when leaving for REPORT
                    if (!last_vec && !(DROP_EN && first_det)) vec_q <= vec_q + VEC_W'(1);
                end
                S_REPORT: begin
                    det_site_q  <= site_q;
                    det_stuck_q <= stuck_q;
                    det_hit_q   <= hit_q;
                    det_fv_q    <= first_q;
                    if (hit_q) count_q <= count_q + CNT_W'(1);
                    hit_q   <= 1'b0;
                    first_q <= '0;
                    vec_q   <= '0;
                    if (!last_fault) begin
                        if (stuck_q) begin
                            stuck_q <= 1'b0;
                            site_q  <= site_q + SITE_W'(1);
                        end else begin
                            stuck_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign vec            = vec_q;
    assign fault_site     = site_q;
    assign stuck_val      = stuck_q;
    assign detected_count = count_q;

    // Result fields show the finishing fault during REPORT, then hold
    assign det_site      = (state == S_REPORT) ? site_q  : det_site_q;
    assign det_stuck     = (state == S_REPORT) ? stuck_q : det_stuck_q;
    assign det_hit       = (state == S_REPORT) ? hit_q   : det_hit_q;
    assign det_first_vec = (state == S_REPORT) ? first_q : det_fv_q;

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Testbench for fault_campaign_ctrl. The faulty adder has its A^B node
// forced only when fault_enable is set and the site is 0. The reference
// model expands each accepted start into the full list of per-cycle
// expectations derived from the vector/fault walk and the adder truth.
module tb_fault_campaign_ctrl;
    localparam int NUM_SITES  = 4;
    localparam int VEC_W      = 3;
    localparam int SETTLE_CYC = 1;
    localparam int SITE_W     = 2;
    localparam int CNT_W      = 4;
    localparam int NV         = 1 << VEC_W;
    localparam int VPC        = SETTLE_CYC + 2;
    localparam int OW         = 6 + SITE_W + VEC_W + CNT_W;
`ifdef FAULT_DROP_EN
    localparam bit DROP    = 1'b1;
    localparam int PIN_GAP = (3 * VPC + 1) + (1 * VPC + 1) + 6 * (8 * VPC + 1);
`else
    localparam bit DROP    = 1'b0;
    localparam int PIN_GAP = 8 * (8 * VPC + 1);
`endif

    localparam int K_APPLY  = 0;
    localparam int K_WAIT   = 1;
    localparam int K_SAMPLE = 2;
    localparam int K_REPORT = 3;
    localparam int K_DONE   = 4;

    typedef struct {
        int                kind;
        logic [VEC_W-1:0]  vec;
        logic [SITE_W-1:0] site;
        logic              stuck;
        logic [SITE_W-1:0] dsite;
        logic              dstuck;
        logic              dhit;
        logic [VEC_W-1:0]  dfv;
        logic [CNT_W-1:0]  cnt;
    } rec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [VEC_W-1:0]  vec;
    logic              fault_enable;
    logic              stuck_val;
    logic [SITE_W-1:0] fault_site;
    logic              fault_sum;
    logic              fault_cout;
    logic              busy;
    logic              det_valid;
    logic [SITE_W-1:0] det_site;
    logic              det_stuck;
    logic              det_hit;
    logic [VEC_W-1:0]  det_first_vec;
    logic [CNT_W-1:0]  detected_count;
    logic              done;

    logic [1:0] noise = 2'b00;
    logic [1:0] good_o, bad_o;

    int checks = 0;
    int errors = 0;

    rec_t q[$];
    logic [SITE_W-1:0] h_site  = '0;
    logic              h_stuck = 1'b0;
    logic              h_hit   = 1'b0;
    logic [VEC_W-1:0]  h_fv    = '0;
    logic [CNT_W-1:0]  h_cnt   = '0;

    fault_campaign_ctrl #(
        .NUM_SITES (NUM_SITES),
        .VEC_W     (VEC_W),
        .SETTLE_CYC(SETTLE_CYC),
        .SITE_W    (SITE_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .vec           (vec),
        .fault_enable  (fault_enable),
        .stuck_val     (stuck_val),
        .fault_site    (fault_site),
        .fault_sum     (fault_sum),
        .fault_cout    (fault_cout),
        .busy          (busy),
        .det_valid     (det_valid),
        .det_site      (det_site),
        .det_stuck     (det_stuck),
        .det_hit       (det_hit),
        .det_first_vec (det_first_vec),
        .detected_count(detected_count),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Full adder with the A^B node optionally forced; returns {cout, sum}
    function automatic logic [1:0] adder(input logic [VEC_W-1:0] v, input logic force_en, input logic sv);
        logic a, b, c, x1;
        a  = v[2];
        b  = v[1];
        c  = v[0];
        x1 = force_en ? sv : (a ^ b);
        return {(a & b) | (x1 & c), x1 ^ c};
    endfunction

    assign good_o     = adder(vec, 1'b0, 1'b0);
    assign bad_o      = adder(vec, fault_enable && (fault_site == '0), stuck_val);
    assign fault_sum  = (good_o[0] ^ bad_o[0]) | noise[0];
    assign fault_cout = (good_o[1] ^ bad_o[1]) | noise[1];

    // A fault is detected on a vector when the forced adder disagrees with a+b+c
    function automatic logic detects(input int s, input int k, input int v);
        logic [1:0] good;
        logic [1:0] bad;
        good = 2'(((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1));
        bad  = adder(VEC_W'(v), s == 0, k[0]);
        return good != bad;
    endfunction

    task automatic gen_campaign();
        rec_t r;
        logic hit;
        logic [VEC_W-1:0] fv;
        int c;
        c = 0;
        r.dsite  = h_site;
        r.dstuck = h_stuck;
        r.dhit   = h_hit;
        r.dfv    = h_fv;
        r.vec    = '0;
        for (int s = 0; s < NUM_SITES; s++) begin
            for (int k = 0; k < 2; k++) begin
                hit = 1'b0;
                fv  = '0;
                r.site  = SITE_W'(s);
                r.stuck = k[0];
                r.cnt   = CNT_W'(c);
                for (int v = 0; v < NV; v++) begin
                    r.vec  = VEC_W'(v);
                    r.kind = K_APPLY;
                    q.push_back(r);
                    r.kind = K_WAIT;
                    for (int w = 0; w < SETTLE_CYC; w++) q.push_back(r);
                    r.kind = K_SAMPLE;
                    q.push_back(r);
                    if (!hit && detects(s, k, v)) begin
                        hit = 1'b1;
                        fv  = VEC_W'(v);
                        if (DROP) break;
                    end
                end
                r.kind   = K_REPORT;
                r.dsite  = SITE_W'(s);
                r.dstuck = k[0];
                r.dhit   = hit;
                r.dfv    = fv;
                q.push_back(r);
                c = c + (hit ? 1 : 0);
            end
        end
        r.kind = K_DONE;
        r.cnt  = CNT_W'(c);
        q.push_back(r);
    endtask

    // Reference model: advance one expectation per clock
    initial begin : model
        rec_t r;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
                h_site  = '0;
                h_stuck = 1'b0;
                h_hit   = 1'b0;
                h_fv    = '0;
                h_cnt   = '0;
            end else if (q.size() > 0) begin
                r       = q.pop_front();
                h_site  = r.dsite;
                h_stuck = r.dstuck;
                h_hit   = r.dhit;
                h_fv    = r.dfv;
                h_cnt   = r.cnt + ((r.kind == K_REPORT && r.dhit) ? CNT_W'(1) : CNT_W'(0));
                if (abort) q.delete();
            end else if (start && !abort) begin
                gen_campaign();
            end
        end
    end

    // Compare every cycle; flags get random noise except on sample cycles
    initial begin : compare
        rec_t c;
        logic [OW-1:0] got_o, exp_o;
        forever begin
            @(negedge clk);
            got_o = {busy, fault_enable, done, det_valid, det_site, det_stuck,
                     det_hit, det_first_vec, detected_count};
            if (q.size() > 0) begin
                c = q[0];
                exp_o = {c.kind != K_DONE, c.kind != K_DONE, c.kind == K_DONE, c.kind == K_REPORT,
                         c.dsite, c.dstuck, c.dhit, c.dfv, c.cnt};
            end else begin
                exp_o = {4'b0000, h_site, h_stuck, h_hit, h_fv, h_cnt};
            end
            checks++;
            if (got_o !== exp_o) begin
                errors++;
                $display("FAIL outputs t=%0t got=%b exp=%b", $time, got_o, exp_o);
            end
            if (q.size() > 0 && c.kind != K_DONE) begin
                checks++;
                if ({vec, fault_site, stuck_val} !== {c.vec, c.site, c.stuck}) begin
                    errors++;
                    $display("FAIL drive t=%0t got=%b exp=%b", $time,
                             {vec, fault_site, stuck_val}, {c.vec, c.site, c.stuck});
                end
            end
            if (q.size() > 0 && q[0].kind == K_SAMPLE) noise = 2'b00;
            else                                       noise = 2'($urandom_range(0, 3));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, 32'({vec, fault_enable, stuck_val, fault_site, busy, det_valid, det_site,
                         det_stuck, det_hit, det_first_vec, detected_count, done}), 32'd0);
    endtask

    int exp_hit [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
    int exp_fv  [8] = '{2, 0, 0, 0, 0, 0, 0, 0};
    logic [SITE_W+VEC_W+1:0] cap [8];

    initial begin : stim
        int gap;
        int n_det;
        int found;
        int tgt;
        tgt = (SETTLE_CYC > 0) ? K_WAIT : K_SAMPLE;

        repeat (3) tick();
        check_all_zero("reset_state");
        rst = 1'b0;
        tick();

        // Full campaign: per-fault results, end timing, final count
        start = 1'b1;
        tick();
        start = 1'b0;
        gap   = -1;
        n_det = 0;
        for (int n = 1; n <= 1000; n++) begin
            tick();
            if (det_valid) begin
                if (n_det < 8) cap[n_det] = {det_site, det_stuck, det_hit, det_first_vec};
                n_det++;
            end
            if (done) begin
                gap = n;
                break;
            end
        end
        check("done_gap", 32'(gap), 32'(PIN_GAP));
        check("det_pulses", 32'(n_det), 32'd8);
        for (int i = 0; i < 8; i++)
            check("det_fault", 32'(cap[i]),
                  32'({SITE_W'(i >> 1), 1'(i & 1), 1'(exp_hit[i]), VEC_W'(exp_fv[i])}));
        check("count_final", 32'(detected_count), 32'd2);
        tick();

        // Abort while fault (0,1) is settling
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 0;
        for (int n = 0; n < 200; n++) begin
            if (q.size() > 0 && q[0].kind == tgt && q[0].site == '0 && q[0].stuck == 1'b1) begin
                found = 1;
                break;
            end
            tick();
        end
        check("abort_target_found", 32'(found), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", 32'({busy, fault_enable, done, det_valid}), 32'd0);
        check("abort_count", 32'(detected_count), 32'd1);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_state", 32'({busy, detected_count, fault_site, stuck_val, vec}),
              32'({1'b1, CNT_W'(0), SITE_W'(0), 1'b0, VEC_W'(0)}));

        // Asynchronous reset in the middle of a sample cycle
        found = 0;
        for (int n = 0; n < 50; n++) begin
            if (q.size() > 0 && q[0].kind == K_SAMPLE && q[0].vec == VEC_W'(2)) begin
                found = 1;
                break;
            end
            tick();
        end
        check("sample_target_found", 32'(found), 32'd1);
        #1 rst = 1'b1;
        #1 check_all_zero("async_reset");
        #3 rst = 1'b0;
        tick();

        // Random start/abort traffic, including start while busy
        for (int n = 0; n < 3000; n++) begin
            start = ($urandom_range(0, 19) == 0);
            abort = ($urandom_range(0, 299) == 0);
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
